// File: rtl/serializador_param.sv
// serializador_param
//   Word-to-lane serializer for the PHY transmit path. Accepts IN_W-bit words
//   on a valid/ready handshake and emits IN_MODE+1 pieces of OUT_W bits, from
//   lane IN_MODE down to lane 0. A one-word pending buffer lets the next word
//   load into the active register with no bubble at word boundaries.
//
// Ports
//   CLK        sole clock, posedge
//   RST        synchronous active-high reset, highest priority
//   ENB        block enable; 0 discards active and pending words
//   IN_VALID   word offered on IN_DATA/IN_MODE
//   IN_READY   block can take a word this cycle (pending slot empty)
//   IN_DATA    word to serialize
//   IN_MODE    piece count minus one, captured with the word
//   OUT_VALID  OUT_DATA holds a piece
//   OUT_READY  downstream takes the piece
//   OUT_DATA   current piece (0 when invalid or disabled)
//   OUT_LAST   current piece is the last of its word
module serializador_param #(
  parameter  int IN_W  = 32,
  parameter  int OUT_W = 8,
  parameter  int LANES = 4,
  localparam int MW    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ENB,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [IN_W-1:0]  IN_DATA,
  input  logic [MW-1:0]    IN_MODE,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [OUT_W-1:0] OUT_DATA,
  output logic             OUT_LAST
);

  logic            a_valid_q, a_valid_d;
  logic [IN_W-1:0] a_word_q,  a_word_d;
  logic [MW-1:0]   a_idx_q,   a_idx_d;
  logic            p_valid_q, p_valid_d;
  logic [IN_W-1:0] p_word_q,  p_word_d;
  logic [MW-1:0]   p_mode_q,  p_mode_d;

  logic accept;
  logic fire;
  logic done;
  logic a_free;

  // IN_READY looks only at registered pending state, so downstream
  // backpressure reaches the input one cycle late rather than combinationally.
  assign IN_READY  = ENB & ~RST & ~p_valid_q;
  assign OUT_VALID = a_valid_q;
  assign OUT_LAST  = a_valid_q & (a_idx_q == '0);
  assign OUT_DATA  = (a_valid_q && ENB) ? a_word_q[a_idx_q*OUT_W +: OUT_W] : '0;

  assign accept = IN_VALID & IN_READY;
  assign fire   = OUT_VALID & OUT_READY;
  assign done   = fire & OUT_LAST;
  assign a_free = ~a_valid_q | done;

  always_comb begin
    a_valid_d = a_valid_q;
    a_word_d  = a_word_q;
    a_idx_d   = a_idx_q;
    p_valid_d = p_valid_q;
    p_word_d  = p_word_q;
    p_mode_d  = p_mode_q;

    if (a_free) begin
      if (p_valid_q) begin
        a_valid_d = 1'b1;
        a_word_d  = p_word_q;
        a_idx_d   = p_mode_q;
        p_valid_d = 1'b0;
      end else if (accept) begin
        a_valid_d = 1'b1;
        a_word_d  = IN_DATA;
        a_idx_d   = IN_MODE;
      end else begin
        a_valid_d = 1'b0;
      end
    end else if (fire) begin
      a_idx_d = a_idx_q - 1'b1;
    end

    // accept implies p_valid_q=0, so a word that did not go straight into a
    // busy active register always finds the pending slot free.
    if (accept && !a_free) begin
      p_valid_d = 1'b1;
      p_word_d  = IN_DATA;
      p_mode_d  = IN_MODE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || !ENB) begin
      a_valid_q <= 1'b0;
      a_idx_q   <= '0;
      p_valid_q <= 1'b0;
    end else begin
      a_valid_q <= a_valid_d;
      a_idx_q   <= a_idx_d;
      p_valid_q <= p_valid_d;
    end
  end

  // Word/mode payload needs no reset: it is only observed behind a valid bit.
  always_ff @(posedge CLK) begin
    a_word_q <= a_word_d;
    p_word_q <= p_word_d;
    p_mode_q <= p_mode_d;
  end

endmodule

// File: doc/serializador_param.md
# serializador_param

Parametrised word-to-lane serializer for the PHY transmit path. It accepts IN_W-bit words over a valid/ready handshake and emits them as OUT_W-bit pieces, most significant first, with a per-word piece count. A one-word pending buffer lets the next word load with no bubble. Output backpressure and a last-piece marker let it feed framing logic directly.

## Interface

- IN_W, 32, input word width; must equal OUT_W*LANES.
- OUT_W, 8, output piece width.
- LANES, 4, pieces per full word; power of two, ≥2.
- Derived: MW = log2(LANES).

- CLK  in  1  sole clock; all state updates on posedge.
- RST  in  1  synchronous, active-high reset.
- ENB  in  1  block enable; 0 = flush.
- IN_VALID  in  1  IN_DATA/IN_MODE offered.
- IN_READY  out  1  block can accept a word this cycle.
- IN_DATA  in  IN_W  word to serialize.
- IN_MODE  in  MW  piece count minus one. The block emits IN_MODE+1 pieces from the least-significant IN_MODE+1 lanes.
- OUT_VALID  out  1  OUT_DATA holds a valid piece.
- OUT_READY  in  1  downstream takes the piece.
- OUT_DATA  out  OUT_W  current piece.
- OUT_LAST  out  1  current piece is the final piece of its word.

## Operation

- State:
  - active register: a_valid, a_word, a_idx (MW bits).
  - pending register: p_valid, p_word, p_mode.
- Outputs:
  - OUT_VALID = a_valid.
  - OUT_DATA = a_word[a_idx*OUT_W +: OUT_W] when a_valid, else 0.
  - OUT_LAST = a_valid & (a_idx==0).
  - IN_READY = ENB & !RST & !p_valid.
- Events:
  - accept = IN_VALID & IN_READY.
  - fire = OUT_VALID & OUT_READY.
  - done = fire & OUT_LAST.
- Active update, priority order:
  1. Active register free (!a_valid or done) and p_valid: load p_word, set a_idx=p_mode, clear p_valid.
  2. Active register free and accept: load IN_DATA, set a_idx=IN_MODE.
  3. Active register free, nothing available: clear a_valid.
  4. Otherwise, on fire: a_idx decrements by 1.
  5. Otherwise: hold.
- Pending update: on accept, if the word was not loaded into active (case 2), it goes to pending (p_word=IN_DATA, p_mode=IN_MODE, p_valid=1).
- Emission order: lanes IN_MODE down to 0.
  - IN_MODE=LANES-1: all lanes, MSB first.
  - IN_MODE=0: lane 0 only. OUT_LAST is asserted on that single piece.
- IN_MODE is captured with the word. Changing IN_MODE while a word is in flight has no effect on that word.
- ENB=0 (flush), next edge:
  - a_valid=0, p_valid=0, a_idx=0.
  - In-flight and pending words are discarded.
  - OUT_DATA=0, IN_READY=0 while ENB=0.
- RST=1: same register values as flush, regardless of ENB. RST takes priority over everything.
- IN_DATA is ignored when accept=0. OUT_DATA never changes while OUT_VALID=1 & OUT_READY=0.

## Timing

- Reset values:
  - OUT_VALID=0, OUT_DATA=0, OUT_LAST=0.
  - IN_READY=0 during reset.
  - IN_READY=1 the cycle after RST deasserts, if ENB=1.
- Latency: a word accepted into an empty block at edge t gives its first piece valid from edge t (visible in cycle t+1). No combinational path from IN_* to OUT_*.
- OUT_READY→IN_READY is registered only; IN_READY depends on p_valid.
- Throughput:
  - With OUT_READY=1 and words always offered, one piece per cycle with no bubble at word boundaries.
  - A word of k pieces occupies exactly k cycles.
- Simultaneous done and accept with p_valid=0: the input word goes straight into active; pending stays empty.
- Back-to-back MODE=0 words: each takes 1 cycle. Pending cycles every cycle at most; IN_READY stays 1.
- Mid-word RST or ENB drop: output is invalid the next cycle and the partial word is lost. No partial-word replay.

## Test plan

- **Reset:** RST=1 for 2 cycles with ENB=1 and IN_VALID=1 → OUT_VALID=0, OUT_DATA=0, IN_READY=0. After release, IN_READY=1.
- **Full word:** ENB=1, OUT_READY=1, one word 0xA1B2C3D4 with MODE=3 → OUT_DATA A1, B2, C3, D4 on 4 consecutive cycles, OUT_LAST only on D4. Then OUT_VALID=0.
- **Modes:**
  - 0x11223344 with MODE=1 → 33, 44 (LAST on 44).
  - Then MODE=0 → 44 alone, with LAST.
- **Streaming:** 0x01020304 (MODE=3) then 0x05060708 (MODE=3) offered back-to-back, OUT_READY=1 → 8 pieces 01..08 on 8 consecutive cycles with no gap. IN_READY drops while pending is full.
- **Backpressure:** OUT_READY=0 for 3 cycles mid-word (on piece B2 of 0xA1B2C3D4) → OUT_DATA holds B2. A second word is accepted into pending, then IN_READY=0 until pending drains. Order is preserved.
- **Flush:** ENB=0 for 1 cycle during piece C3 with a word pending → next cycle OUT_VALID=0, OUT_DATA=0. After ENB=1, the block is empty and accepts a new word normally.
